skew_feed_ctrl: RTL and testbench

SKEW_FEED_CTRL -- requirements
Module: skew_feed_ctrl

---
 rtl/skew_ctrl_pkg.sv | 15 +
 rtl/skew_tag_sr.sv | 22 ++
 rtl/skew_feed_ctrl.sv | 134 +++++++++++++
 tb/tb_skew_feed_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/skew_ctrl_pkg.sv
// Shared definitions for the skew feed controller: FSM state encoding and
// default geometry constants used by skew_feed_ctrl and its bench.
package skew_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DATA_WIDTH_DEF = 22;
  localparam int TILE_COLS_DEF  = 6;

endpackage

// File: rtl/skew_tag_sr.sv
// Tag shift register that tracks which skew-stage slots hold real beats.
// q[0] takes din on each advance; q[k] takes q[k-1]. Holds when adv is low.
module skew_tag_sr #(
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             din,
  output logic [DEPTH-1:0] q
);

  // Shift the tag chain in lock-step with the skew stage strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (adv) begin
      q <= {q[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/skew_feed_ctrl.sv
// Skew feed controller: accepts len column beats per tile, forwards them to a
// skew stage, then pushes TILE_COLS+1 zero strobes to drain it. array_stall
// freezes the skew stage. Optional performance counters are built only when
// SKEW_PERF_CNT_EN is defined; otherwise stall_cnt/tile_cnt read as zero.
module skew_feed_ctrl
  import skew_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TILE_COLS  = TILE_COLS_DEF,
  parameter int LEN_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEN_W-1:0]                len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*TILE_COLS-1:0] in_data,
  input  logic                            array_stall,
  output logic                            skew_en,
  output logic [DATA_WIDTH*TILE_COLS-1:0] skew_din,
  output logic [TILE_COLS-1:0]            lane_valid,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     stall_cnt,
  output logic [31:0]                     tile_cnt
);

  localparam int FC_W = $clog2(TILE_COLS + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beats_left_q, beats_left_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             accept;
  logic             flush_stb;
  logic [TILE_COLS:0] tag_q;
  logic             unused_tag0;

  assign in_ready  = (state_q == FEED) && !array_stall && (beats_left_q != '0);
  assign accept    = in_valid && in_ready;
  assign flush_stb = (state_q == FLUSH) && !array_stall;
  assign skew_en   = accept || flush_stb;
  assign skew_din  = accept ? in_data : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Next-state and counter update; start is only honoured in IDLE
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    flush_cnt_d  = flush_cnt_q;
    case (state_q)
      IDLE: begin
        flush_cnt_d = '0;
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d      = FEED;
            beats_left_d = len;
          end
        end
      end
      FEED: begin
        if (accept) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == LEN_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_stb) begin
          if (flush_cnt_q == FC_W'(TILE_COLS)) begin
            flush_cnt_d = '0;
            state_d     = DONE;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and tile counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  skew_tag_sr #(
    .DEPTH (TILE_COLS + 1)
  ) u_tag_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (skew_en),
    .din   (accept),
    .q     (tag_q)
  );

  // Slot 0 is still inside the skew stage input register; lanes start at 1
  assign lane_valid  = tag_q[TILE_COLS:1];
  assign unused_tag0 = tag_q[0];

`ifdef SKEW_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] tile_cnt_q;

  // Stall cycles while busy and completed tiles, both free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      tile_cnt_q  <= '0;
    end else begin
      if (busy && array_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (done)                tile_cnt_q  <= tile_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign tile_cnt  = tile_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign tile_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Bench for skew_feed_ctrl: directed tile scenarios plus randomized traffic
// compared against a tile-level reference model every cycle.
module tb_skew_feed_ctrl;
  localparam int DW = 22;
  localparam int TC = 6;
  localparam int LW = 16;
  localparam int W  = DW * TC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          array_stall;
  logic          skew_en;
  logic [W-1:0]  skew_din;
  logic [TC-1:0] lane_valid;
  logic          busy;
  logic          done;
  logic [31:0]   stall_cnt;
  logic [31:0]   tile_cnt;

  skew_feed_ctrl #(.DATA_WIDTH(DW), .TILE_COLS(TC), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .array_stall(array_stall), .skew_en(skew_en), .skew_din(skew_din),
    .lane_valid(lane_valid), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: tile-level view
  bit          m_busy, m_done;
  int          m_beats, m_flush;
  bit          tags[TC+1];
  logic [31:0] m_stalls, m_tiles;

  // Observation counters for directed scenarios
  int cyc = 0, start_cyc = 0, done_cyc = -1, en_cnt = 0, lv5_cnt = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_beats = 0; m_flush = 0;
    for (int k = 0; k <= TC; k++) tags[k] = 0;
    m_stalls = 0; m_tiles = 0;
  endtask

  task automatic clr_obs();
    done_cyc = -1; en_cnt = 0; lv5_cnt = 0; done_cnt = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    start = 0; in_valid = 1; array_stall = 0;
    rst_n = 0;
    #2;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_en", W'(skew_en), W'(0));
    check("rst_ready", W'(in_ready), W'(0));
    check("rst_lv", W'(lane_valid), W'(0));
    check("rst_din", skew_din, W'(0));
    check("rst_scnt", W'(stall_cnt), W'(0));
    check("rst_tcnt", W'(tile_cnt), W'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    in_valid = 0;
  endtask

  // One clock of stimulus; expects to be called at posedge+1
  task automatic step(input bit do_start, input int ln, input bit vld, input bit stl);
    logic [159:0] rnd;
    logic [TC-1:0] e_lv;
    logic [31:0] e_sc, e_tc;
    bit feeding, flushing, e_ready, acc, fstb, e_en;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    start = do_start; len = LW'(ln); in_valid = vld; array_stall = stl;
    in_data = rnd[W-1:0];
    if (do_start && !m_busy) start_cyc = cyc;
    @(negedge clk);
    feeding  = m_busy && !m_done && (m_beats > 0);
    flushing = m_busy && !m_done && (m_beats == 0) && (m_flush > 0);
    e_ready  = feeding && !stl;
    acc      = e_ready && vld;
    fstb     = flushing && !stl;
    e_en     = acc || fstb;
    for (int i = 0; i < TC; i++) e_lv[i] = tags[i+1];
`ifdef SKEW_PERF_CNT_EN
    e_sc = m_stalls; e_tc = m_tiles;
`else
    e_sc = 0; e_tc = 0;
`endif
    check("in_ready", W'(in_ready), W'(e_ready));
    check("skew_en", W'(skew_en), W'(e_en));
    check("skew_din", skew_din, acc ? in_data : W'(0));
    check("lane_valid", W'(lane_valid), W'(e_lv));
    check("busy", W'(busy), W'(m_busy));
    check("done", W'(done), W'(m_done));
    check("stall_cnt", W'(stall_cnt), W'(e_sc));
    check("tile_cnt", W'(tile_cnt), W'(e_tc));
    if (skew_en === 1'b1) en_cnt++;
    if (skew_en === 1'b1 && lane_valid[TC-1] === 1'b1) lv5_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc - start_cyc;
    end
    // advance model
    if (m_busy && stl) m_stalls++;
    if (m_done) m_tiles++;
    if (e_en) begin
      for (int k = TC; k > 0; k--) tags[k] = tags[k-1];
      tags[0] = acc;
    end
    if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (!m_busy) begin
      if (do_start) begin
        m_busy = 1;
        if (ln == 0) m_done = 1;
        else begin m_beats = ln; m_flush = TC + 1; end
      end
    end else begin
      if (acc) m_beats--;
      if (fstb) begin
        m_flush--;
        if (m_flush == 0) m_done = 1;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  logic [31:0] sc0, tc0;

  initial begin
    rst_n = 0; start = 0; len = 0; in_valid = 0; in_data = '0; array_stall = 0;
    #1;
    do_reset();

    // basic tile, len=4, no gaps
    clr_obs();
    step(1, 4, 0, 0);
    repeat (20) step(0, 0, 1, 0);
    check("A_done_cyc", W'(done_cyc), W'(12));
    check("A_en_cnt", W'(en_cnt), W'(11));
    check("A_lv5", W'(lv5_cnt), W'(4));

    // 3-cycle valid gap after beat 2
    clr_obs();
    step(1, 4, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (20) step(0, 0, 1, 0);
    check("B_done_cyc", W'(done_cyc), W'(15));
    check("B_en_cnt", W'(en_cnt), W'(11));

    // 2-cycle stall inside flush
    clr_obs();
    sc0 = stall_cnt; tc0 = tile_cnt;
    step(1, 4, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    repeat (2) step(0, 0, 1, 1);
    repeat (20) step(0, 0, 1, 0);
    check("C_done_cyc", W'(done_cyc), W'(14));
    check("C_en_cnt", W'(en_cnt), W'(11));
`ifdef SKEW_PERF_CNT_EN
    check("C_stall_delta", W'(stall_cnt - sc0), W'(2));
`else
    check("C_stall_delta", W'(stall_cnt - sc0), W'(0));
`endif

    // zero-length tile
    clr_obs();
    tc0 = tile_cnt;
    step(1, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    check("D_done_cyc", W'(done_cyc), W'(1));
    check("D_en_cnt", W'(en_cnt), W'(0));
`ifdef SKEW_PERF_CNT_EN
    check("D_tile_delta", W'(tile_cnt - tc0), W'(1));
`else
    check("D_tile_delta", W'(tile_cnt - tc0), W'(0));
`endif

    // start re-pulsed during FEED is ignored
    clr_obs();
    step(1, 4, 0, 0);
    step(0, 0, 1, 0);
    step(1, 2, 1, 0);
    repeat (20) step(0, 0, 1, 0);
    check("E_done_cyc", W'(done_cyc), W'(12));
    check("E_en_cnt", W'(en_cnt), W'(11));
    check("E_done_cnt", W'(done_cnt), W'(1));

    // reset during FLUSH, then no activity without a new start
    step(1, 4, 0, 0);
    repeat (6) step(0, 0, 1, 0);
    do_reset();
    clr_obs();
    repeat (6) step(0, 3, 1, 0);
    check("F_en_cnt", W'(en_cnt), W'(0));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int ln;
      ln = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 5));
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 5) == 0, ln, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
